ans_rans_encoder: RTL and testbench
===================================

Name: ans_rans_encoder

Overview:
Parametrised single-clock rANS entropy encoder; the successor to the fixed 4-bit ans load/enc block.
- Adds per-symbol frequencies of arbitrary width, a cumulative table, a real rANS state register with renormalisation, a sequential divider and a flush command.
- Replaces per-mode clock gating with one free-running clock and an explicit FSM.
- Sits between the tt_um top-level pins and the symbol source.

Parameters:
SYM_WIDTH, 4, symbol width; SYM_COUNT = 2**SYM_WIDTH
CNT_WIDTH, 5, frequency word width
PROB_BITS, 4, log2 of total frequency M; loaded table must sum to 2**PROB_BITS
STATE_WIDTH, 16, rANS state width; L = 2**(STATE_WIDTH-OUT_WIDTH)
OUT_WIDTH, 4, output chunk width; STATE_WIDTH divisible by OUT_WIDTH; PROB_BITS <= STATE_WIDTH-OUT_WIDTH (elaboration error otherwise)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cmd  in  2  00 idle, 01 encode, 10 flush, 11 load; sampled only in IDLE
in  in  max(SYM_WIDTH,CNT_WIDTH)  symbol (low SYM_WIDTH bits) or frequency word
in_vld  in  1  input valid
in_rdy  out  1  input ready
out  out  OUT_WIDTH  output chunk
out_vld  out  1  output valid
out_rdy  in  1  output ready
busy  out  1  FSM not in IDLE
tbl_err  out  1  last load summed to a value other than M; cleared by the next load start
sym_err  out  1  sticky; a zero-frequency symbol was offered; cleared by load start or reset

Behaviour:
- Single clock, no gated clocks. Reset is asynchronous and active-low.
- Reset values: FSM=IDLE, x=L, all freq/cum=0, tbl_valid=0, tbl_err=0, sym_err=0, in_rdy=0, out_vld=0, out=0, busy=0.
- A transfer occurs on a rising edge with vld&rdy. out is held stable while out_vld=1 and out_rdy=0.
- IDLE:
  - cmd=11: in_rdy=1. The first accepted word is freq[0] and the FSM goes to LOAD.
  - cmd=01 with tbl_valid=1: in_rdy=1. On accept, latch sym, f=freq[sym], c=cum[sym]. If f==0, set sym_err, drop the symbol, stay IDLE with x unchanged. Otherwise go to RENORM.
  - cmd=01 with tbl_valid=0: in_rdy=0.
  - cmd=10: go to FLUSH with chunk counter=0.
  - cmd=00: in_rdy=0.
- LOAD:
  - in_rdy=1; accepts freq[1]..freq[SYM_COUNT-1] in order. cum[i] = sum of freq[0..i-1] (PROB_BITS+1 bits wide plus carry guard).
  - Changes on cmd are ignored until the load completes.
  - After the last word: tbl_valid=(sum==M), tbl_err=(sum!=M), go to IDLE.
- RENORM:
  - Condition: x >= (f << (STATE_WIDTH-PROB_BITS)), compared at STATE_WIDTH+1 bits.
  - While the condition holds: out_vld=1, out=x[OUT_WIDTH-1:0]. On out_rdy, x <= x >> OUT_WIDTH and the condition is re-evaluated next cycle.
  - When the condition is false: start the divider (x, f) and go to DIV.
- DIV:
  - The divider takes exactly STATE_WIDTH cycles to produce q and r.
  - On done: x <= (q << PROB_BITS) + r + c, then go to IDLE. The result always lies in [L, 2**STATE_WIDTH).
- Latency: a symbol accepted at edge N with no renorm gives in_rdy=1 again at cycle N+STATE_WIDTH+2. Each emitted chunk adds one cycle, plus any backpressure cycles.
- FLUSH:
  - Emits STATE_WIDTH/OUT_WIDTH chunks of x, least-significant first, each under the out handshake.
  - After the last chunk, x <= L and the FSM returns to IDLE. in_rdy=0 throughout.
- Reset mid-operation (any state): immediate return to reset values. The table is lost, so tbl_valid=0.

Decomposition:
- Package ans_pkg holds:
  - FSM state enum (IDLE, LOAD, RENORM, DIV, FLUSH);
  - cmd encodings CMD_IDLE/ENC/FLUSH/LOAD;
  - derived constants SYM_COUNT, L, CHUNKS=STATE_WIDTH/OUT_WIDTH.
- One sub-module, ans_seq_div:
  - restoring divider, STATE_WIDTH-bit dividend, CNT_WIDTH-bit divisor;
  - start/done pulse interface; q and r held until the next start;
  - same clk/rst_n.

Test Plan:
1. Uniform table: load sixteen 1s -> tbl_valid=1, tbl_err=0. Encode sym 5 -> one chunk out=0x0, and after DIV x=0x1005.
2. Continuing from 1: encode sym 3 -> out=0x5, x=0x1003. Then flush -> chunks 0x3,0x0,0x0,0x1 in that order, then x=0x1000 and busy=0.
3. Load sixteen 2s (sum 32) -> tbl_err=1, tbl_valid=0. cmd=01 with in_vld=1 -> in_rdy stays 0 and no output.
4. Table freq[0]=16, others 0:
   - encode sym 1 -> sym_err=1, no out_vld, x unchanged;
   - encode sym 0 -> no renorm, x stays 0x1000, in_rdy returns 18 cycles after accept.
5. Backpressure: during step 2's flush, hold out_rdy=0 for 5 cycles per chunk -> out_vld and out are stable, there is no chunk loss or duplication, and the same chunk order appears.
6. Assert rst_n=0 mid-DIV and mid-LOAD -> all outputs read reset values asynchronously. After reset, cmd=01 gives in_rdy=0 until a new valid load.

Source files
------------

// File: rtl/ans_pkg.sv
// Shared types and helpers for the rANS encoder: FSM states, command codes
// and the constants derived from the width parameters.
package ans_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RENORM,
        DIV,
        FLUSH
    } state_t;

    localparam logic [1:0] CMD_IDLE  = 2'b00;
    localparam logic [1:0] CMD_ENC   = 2'b01;
    localparam logic [1:0] CMD_FLUSH = 2'b10;
    localparam logic [1:0] CMD_LOAD  = 2'b11;

    function automatic int calc_sym_count(input int sym_width);
        return 1 << sym_width;
    endfunction

    function automatic int calc_l(input int state_width, input int out_width);
        return 1 << (state_width - out_width);
    endfunction

    function automatic int calc_chunks(input int state_width, input int out_width);
        return state_width / out_width;
    endfunction

    // Values for the default parameter set
    localparam int SYM_COUNT = calc_sym_count(4);
    localparam int L         = calc_l(16, 4);
    localparam int CHUNKS    = calc_chunks(16, 4);

endpackage

// File: rtl/ans_seq_div.sv
// Restoring divider, one quotient bit per cycle; done pulses STATE_WIDTH
// cycles after start, q and r then hold until the next start.
module ans_seq_div #(
    parameter int STATE_WIDTH = 16,
    parameter int CNT_WIDTH   = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [STATE_WIDTH-1:0] dividend,
    input  logic [CNT_WIDTH-1:0]   divisor,
    output logic                   done,
    output logic [STATE_WIDTH-1:0] q,
    output logic [CNT_WIDTH-1:0]   r
);

    localparam int ITER_W = $clog2(STATE_WIDTH + 1);

    logic [ITER_W-1:0]  iter;
    logic [CNT_WIDTH-1:0] dvs;
    logic [CNT_WIDTH:0]   rem_sh;
    logic [CNT_WIDTH-1:0] r_next;
    logic                 fits;

    // q doubles as the dividend shift register; its MSB feeds the remainder
    assign rem_sh = {r, q[STATE_WIDTH-1]};
    assign fits   = rem_sh >= {1'b0, dvs};
    assign r_next = fits ? CNT_WIDTH'(rem_sh - {1'b0, dvs}) : rem_sh[CNT_WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q    <= '0;
            r    <= '0;
            dvs  <= '0;
            iter <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                q    <= dividend;
                r    <= '0;
                dvs  <= divisor;
                iter <= ITER_W'(STATE_WIDTH);
            end else if (iter != '0) begin
                q    <= {q[STATE_WIDTH-2:0], fits};
                r    <= r_next;
                iter <= iter - ITER_W'(1);
                if (iter == ITER_W'(1))
                    done <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ans_rans_encoder.sv
// rANS encoder: frequency table load, per-symbol renormalise/divide update of
// the state x, and a flush that streams x out least-significant chunk first.
module ans_rans_encoder
    import ans_pkg::*;
#(
    parameter int SYM_WIDTH   = 4,
    parameter int CNT_WIDTH   = 5,
    parameter int PROB_BITS   = 4,
    parameter int STATE_WIDTH = 16,
    parameter int OUT_WIDTH   = 4,
    localparam int IN_W = (SYM_WIDTH > CNT_WIDTH) ? SYM_WIDTH : CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           cmd,
    input  logic [IN_W-1:0]      in,
    input  logic                 in_vld,
    output logic                 in_rdy,
    output logic [OUT_WIDTH-1:0] out,
    output logic                 out_vld,
    input  logic                 out_rdy,
    output logic                 busy,
    output logic                 tbl_err,
    output logic                 sym_err
);

    localparam int N_SYM    = calc_sym_count(SYM_WIDTH);
    localparam int N_CHUNKS = calc_chunks(STATE_WIDTH, OUT_WIDTH);
    localparam int SUM_W    = CNT_WIDTH + SYM_WIDTH;
    localparam int CH_W     = $clog2(N_CHUNKS + 1);
    localparam logic [STATE_WIDTH-1:0] X_LOW = STATE_WIDTH'(calc_l(STATE_WIDTH, OUT_WIDTH));
    localparam logic [SUM_W-1:0]       M_VAL = SUM_W'(1 << PROB_BITS);

    if (STATE_WIDTH % OUT_WIDTH != 0) begin : g_chk_chunk
        $error("STATE_WIDTH must be divisible by OUT_WIDTH");
    end
    if (PROB_BITS > STATE_WIDTH - OUT_WIDTH) begin : g_chk_prob
        $error("PROB_BITS must not exceed STATE_WIDTH-OUT_WIDTH");
    end

    state_t state, state_nxt;

    logic [STATE_WIDTH-1:0] x;
    logic [CNT_WIDTH-1:0]   freq [N_SYM];
    logic [SUM_W-1:0]       cum  [N_SYM];
    logic                   tbl_valid;
    logic [CNT_WIDTH-1:0]   f_reg;
    logic [SUM_W-1:0]       c_reg;
    logic [SUM_W-1:0]       load_sum;
    logic [SYM_WIDTH-1:0]   load_idx;
    logic [CH_W-1:0]        chunk_cnt;

    logic [SYM_WIDTH-1:0]   sym;
    logic [CNT_WIDTH-1:0]   in_cnt;
    logic [CNT_WIDTH-1:0]   enc_f;
    logic [SUM_W-1:0]       sum_next;
    logic                   renorm_need;
    logic                   chunk_last;
    logic                   in_rdy_c;
    logic                   div_start;
    logic                   div_done;
    logic [STATE_WIDTH-1:0] div_q;
    logic [CNT_WIDTH-1:0]   div_r;
    logic [STATE_WIDTH-1:0] x_div;

    assign sym         = in[SYM_WIDTH-1:0];
    assign in_cnt      = in[CNT_WIDTH-1:0];
    assign enc_f       = freq[sym];
    assign sum_next    = load_sum + SUM_W'(in_cnt);
    // One extra bit so f << (STATE_WIDTH-PROB_BITS) cannot wrap when f == M
    assign renorm_need = {1'b0, x} >= ((STATE_WIDTH+1)'(f_reg) << (STATE_WIDTH - PROB_BITS));
    assign chunk_last  = chunk_cnt == CH_W'(N_CHUNKS - 1);
    assign x_div       = (div_q << PROB_BITS) + STATE_WIDTH'(div_r) + STATE_WIDTH'(c_reg);

    ans_seq_div #(
        .STATE_WIDTH (STATE_WIDTH),
        .CNT_WIDTH   (CNT_WIDTH)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (x),
        .divisor  (f_reg),
        .done     (div_done),
        .q        (div_q),
        .r        (div_r)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_rdy_c  = 1'b0;
        out_vld   = 1'b0;
        div_start = 1'b0;
        case (state)
            IDLE: begin
                case (cmd)
                    CMD_LOAD: begin
                        in_rdy_c = 1'b1;
                        if (in_vld) state_nxt = LOAD;
                    end
                    CMD_ENC: begin
                        in_rdy_c = tbl_valid;
                        if (in_vld && tbl_valid && enc_f != '0) state_nxt = RENORM;
                    end
                    CMD_FLUSH: state_nxt = FLUSH;
                    default: ;
                endcase
            end
            LOAD: begin
                in_rdy_c = 1'b1;
                if (in_vld && (&load_idx)) state_nxt = IDLE;
            end
            RENORM: begin
                if (renorm_need) begin
                    out_vld = 1'b1;
                end else begin
                    div_start = 1'b1;
                    state_nxt = DIV;
                end
            end
            DIV: begin
                if (div_done) state_nxt = IDLE;
            end
            FLUSH: begin
                out_vld = 1'b1;
                if (out_rdy && chunk_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Ready is forced low while reset is held, even if cmd requests a load
    assign in_rdy = rst_n & in_rdy_c;
    assign out    = out_vld ? x[OUT_WIDTH-1:0] : '0;
    assign busy   = state != IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x         <= X_LOW;
            freq      <= '{default: '0};
            cum       <= '{default: '0};
            tbl_valid <= 1'b0;
            tbl_err   <= 1'b0;
            sym_err   <= 1'b0;
            f_reg     <= '0;
            c_reg     <= '0;
            load_sum  <= '0;
            load_idx  <= '0;
            chunk_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    chunk_cnt <= '0;
                    if (in_vld && in_rdy) begin
                        if (cmd == CMD_LOAD) begin
                            freq[0]   <= in_cnt;
                            cum[0]    <= '0;
                            load_sum  <= SUM_W'(in_cnt);
                            load_idx  <= SYM_WIDTH'(1);
                            tbl_valid <= 1'b0;
                            tbl_err   <= 1'b0;
                            sym_err   <= 1'b0;
                        end else if (enc_f == '0) begin
                            sym_err <= 1'b1;
                        end else begin
                            f_reg <= enc_f;
                            c_reg <= cum[sym];
                        end
                    end
                end
                LOAD: begin
                    if (in_vld) begin
                        freq[load_idx] <= in_cnt;
                        cum[load_idx]  <= load_sum;
                        load_sum       <= sum_next;
                        load_idx       <= load_idx + SYM_WIDTH'(1);
                        if (&load_idx) begin
                            tbl_valid <= sum_next == M_VAL;
                            tbl_err   <= sum_next != M_VAL;
                        end
                    end
                end
                RENORM: begin
                    if (renorm_need && out_rdy) x <= x >> OUT_WIDTH;
                end
                DIV: begin
                    if (div_done) x <= x_div;
                end
                FLUSH: begin
                    if (out_rdy) begin
                        x         <= chunk_last ? X_LOW : (x >> OUT_WIDTH);
                        chunk_cnt <= chunk_cnt + CH_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ans_rans_encoder.sv
// Bench for ans_rans_encoder: directed table/encode/flush scenarios plus random
// tables and symbols, checked against an arithmetic rANS model.
module tb_ans_rans_encoder;

    localparam int NS  = 16;
    localparam int IW  = 5;
    localparam int STW = 16;
    localparam int LV  = 4096;
    localparam int NCH = 4;
    localparam logic [1:0] C_IDLE = 2'b00, C_ENC = 2'b01, C_FLUSH = 2'b10, C_LOAD = 2'b11;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    cmd = 2'b00;
    logic [IW-1:0] din = '0;
    logic          in_vld = 1'b0;
    logic          in_rdy;
    logic [3:0]    dout;
    logic          out_vld;
    logic          out_rdy = 1'b1;
    logic          busy, tbl_err, sym_err;

    ans_rans_encoder dut (
        .clk(clk), .rst_n(rst_n), .cmd(cmd), .in(din), .in_vld(in_vld), .in_rdy(in_rdy),
        .out(dout), .out_vld(out_vld), .out_rdy(out_rdy), .busy(busy),
        .tbl_err(tbl_err), .sym_err(sym_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int m_freq[NS];
    int m_cum[NS];
    bit m_valid = 0;
    bit m_tbl_err = 0;
    bit m_sym_err = 0;
    int m_x = LV;
    int exp_q[$];
    int obs[$];
    int tab[NS];
    int bp_mode = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        foreach (m_freq[i]) begin
            m_freq[i] = 0;
            m_cum[i] = 0;
        end
        m_valid = 0;
        m_tbl_err = 0;
        m_sym_err = 0;
        m_x = LV;
        exp_q.delete();
    endtask

    // rANS step from the arithmetic definition
    task automatic model_encode(input int sym, output int nch);
        int f;
        f = m_freq[sym];
        nch = 0;
        if (f == 0) begin
            m_sym_err = 1;
        end else begin
            while (m_x >= (f << (STW - 4))) begin
                exp_q.push_back(m_x % 16);
                m_x = m_x / 16;
                nch++;
            end
            m_x = (m_x / f) * 16 + (m_x % f) + m_cum[sym];
        end
    endtask

    task automatic wait_in_rdy(output bit ok);
        ok = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (in_rdy) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("timeout_in_rdy", 0, 1);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_in_rdy"}, in_rdy, 0);
        chk({tag, "_out_vld"}, out_vld, 0);
        chk({tag, "_out"}, dout, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_tbl_err"}, tbl_err, 0);
        chk({tag, "_sym_err"}, sym_err, 0);
    endtask

    task automatic do_load();
        bit ok;
        int sum;
        align();
        cmd = C_LOAD;
        for (int i = 0; i < NS; i++) begin
            din = IW'(tab[i]);
            in_vld = 1'b1;
            wait_in_rdy(ok);
            if (!ok) begin
                in_vld = 1'b0;
                cmd = C_IDLE;
                return;
            end
            @(posedge clk);
            #1;
        end
        in_vld = 1'b0;
        cmd = C_IDLE;
        sum = 0;
        for (int i = 0; i < NS; i++) begin
            m_freq[i] = tab[i];
            m_cum[i] = sum;
            sum += tab[i];
        end
        m_valid = (sum == 16);
        m_tbl_err = !m_valid;
        m_sym_err = 0;
        @(negedge clk);
        chk("load_tbl_err", tbl_err, m_tbl_err);
        chk("load_busy", busy, 0);
        chk("load_sym_err", sym_err, 0);
    endtask

    task automatic do_encode(input int sym, input bit chk_lat);
        bit ok;
        bit fin;
        int n, k, f;
        align();
        cmd = C_ENC;
        din = IW'(sym);
        in_vld = 1'b1;
        wait_in_rdy(ok);
        if (!ok) begin
            in_vld = 1'b0;
            cmd = C_IDLE;
            return;
        end
        @(posedge clk);
        #1;
        in_vld = 1'b0;
        f = m_freq[sym];
        model_encode(sym, n);
        k = 0;
        fin = 0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (!busy) begin
                fin = 1;
                break;
            end
        end
        if (!fin) begin
            chk("timeout_busy_enc", 0, 1);
        end else begin
            if (chk_lat && f != 0) chk("enc_latency", k, STW + 2 + n);
            chk("enc_in_rdy_again", in_rdy, m_valid);
        end
        chk("enc_sym_err", sym_err, m_sym_err);
        cmd = C_IDLE;
    endtask

    task automatic do_flush();
        bit fin;
        bit rdy_seen;
        align();
        cmd = C_FLUSH;
        @(posedge clk);
        #1;
        cmd = C_IDLE;
        for (int i = 0; i < NCH; i++) begin
            exp_q.push_back(m_x % 16);
            m_x = m_x / 16;
        end
        m_x = LV;
        fin = 0;
        rdy_seen = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!busy) begin
                fin = 1;
                break;
            end
            if (in_rdy) rdy_seen = 1;
        end
        if (!fin) chk("timeout_busy_flush", 0, 1);
        chk("flush_in_rdy_low", rdy_seen, 0);
    endtask

    task automatic check_no_accept();
        align();
        cmd = C_ENC;
        din = IW'($urandom_range(0, NS - 1));
        in_vld = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("noacc_in_rdy", in_rdy, 0);
            chk("noacc_out_vld", out_vld, 0);
        end
        chk("noacc_busy", busy, 0);
        align();
        in_vld = 1'b0;
        cmd = C_IDLE;
    endtask

    task automatic chk_obs(input string nm, input int c0, input int c1, input int c2, input int c3, input int n);
        int lit[4];
        lit[0] = c0; lit[1] = c1; lit[2] = c2; lit[3] = c3;
        chk({nm, "_count"}, obs.size(), n);
        for (int i = 0; i < n && i < obs.size(); i++) chk({nm, "_chunk"}, obs[i], lit[i]);
    endtask

    // Backpressure source
    initial begin : rdy_drv
        int hold;
        hold = 0;
        forever begin
            @(posedge clk);
            #1;
            case (bp_mode)
                1: out_rdy = 1'($urandom_range(0, 1));
                2: begin
                    if (out_vld && hold < 5) begin
                        out_rdy = 1'b0;
                        hold++;
                    end else begin
                        out_rdy = 1'b1;
                        hold = 0;
                    end
                end
                default: out_rdy = 1'b1;
            endcase
        end
    end

    // Output compare: every transferred chunk against the model, plus hold stability
    initial begin : mon
        bit hold_prev;
        int prev_out;
        hold_prev = 0;
        prev_out = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_prev = 0;
            end else begin
                if (hold_prev) begin
                    chk("hold_out_vld", out_vld, 1);
                    chk("hold_out", dout, prev_out);
                end
                if (out_vld && out_rdy) begin
                    if (exp_q.size() == 0) chk("unexpected_chunk", 1, 0);
                    else chk("chunk", dout, exp_q.pop_front());
                    obs.push_back(int'(dout));
                end
                hold_prev = out_vld && !out_rdy;
                prev_out = dout;
            end
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit ok;
        int n;
        model_reset();
        #23;
        chk_reset_outs("reset");
        align();
        rst_n = 1'b1;
        check_no_accept();

        // Uniform table
        foreach (tab[i]) tab[i] = 1;
        do_load();
        obs.delete();
        do_encode(5, 1);
        chk("model_x_1005", m_x, 'h1005);
        chk_obs("enc5", 0, 0, 0, 0, 1);
        obs.delete();
        do_encode(3, 1);
        chk("model_x_1003", m_x, 'h1003);
        chk_obs("enc3", 5, 0, 0, 0, 1);
        obs.delete();
        do_flush();
        chk_obs("flush1", 3, 0, 0, 1, 4);
        chk("flush1_busy", busy, 0);

        // Table summing to 32
        foreach (tab[i]) tab[i] = 2;
        do_load();
        chk("bad_tbl_err", tbl_err, 1);
        check_no_accept();

        // Single symbol carries all probability
        foreach (tab[i]) tab[i] = 0;
        tab[0] = 16;
        do_load();
        obs.delete();
        do_encode(1, 1);
        chk("zero_sym_err", sym_err, 1);
        chk("zero_no_out", obs.size(), 0);
        do_encode(0, 1);
        chk("model_x_1000", m_x, 'h1000);
        chk("sym_err_sticky", sym_err, 1);
        obs.delete();
        do_flush();
        chk_obs("flush_x_unchanged", 0, 0, 0, 1, 4);

        // Flush under heavy backpressure
        foreach (tab[i]) tab[i] = 1;
        do_load();
        do_encode(5, 1);
        do_encode(3, 1);
        bp_mode = 2;
        obs.delete();
        do_flush();
        chk_obs("flush_bp", 3, 0, 0, 1, 4);
        bp_mode = 0;

        // Reset during DIV
        align();
        cmd = C_ENC;
        din = IW'(2);
        in_vld = 1'b1;
        wait_in_rdy(ok);
        @(posedge clk);
        #1;
        in_vld = 1'b0;
        cmd = C_IDLE;
        model_encode(2, n);
        repeat (6) @(posedge clk);
        #3;
        chk("mid_div_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk_reset_outs("rst_div");
        model_reset();
        align();
        rst_n = 1'b1;
        check_no_accept();

        // Reset during LOAD, with a load still being requested
        foreach (tab[i]) tab[i] = 1;
        align();
        cmd = C_LOAD;
        din = IW'(1);
        in_vld = 1'b1;
        repeat (5) @(posedge clk);
        #3;
        chk("mid_load_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk_reset_outs("rst_load");
        in_vld = 1'b0;
        cmd = C_IDLE;
        model_reset();
        align();
        rst_n = 1'b1;
        check_no_accept();

        // Random tables and symbol streams
        for (int t = 0; t < 8; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                foreach (tab[i]) tab[i] = $urandom_range(0, 31);
            end else begin
                foreach (tab[i]) tab[i] = 0;
                repeat (16) tab[$urandom_range(0, NS - 1)]++;
            end
            bp_mode = $urandom_range(0, 1);
            do_load();
            if (m_valid) begin
                repeat ($urandom_range(4, 10)) begin
                    if ($urandom_range(0, 9) < 8) do_encode($urandom_range(0, NS - 1), bp_mode == 0);
                    else do_flush();
                end
                do_flush();
            end else begin
                check_no_accept();
            end
        end
        bp_mode = 0;
        repeat (4) align();
        chk("exp_q_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
